// File: rtl/fifo_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter_pkg
// Brief    : Shared FSM state encoding and source identifiers for the
//            lane-FIFO round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_rr_arbiter_pkg;

  // Arbiter FSM states, encoding fixed so it can be probed in the lab
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } arb_state_t;

  // Source identifiers carried alongside an in-flight pop
  localparam logic c_SRC_D0 = 1'b0;
  localparam logic c_SRC_D1 = 1'b1;

endpackage : fifo_rr_arbiter_pkg
`default_nettype wire

// File: rtl/fifo_rr_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter_rr_grant
// Brief    : Two-way round-robin grant. A source is eligible when its FIFO is
//            non-empty and it was not popped last cycle (the empty flag lags
//            a pop by one cycle). Holds the preferred-source pointer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter_rr_grant
  import fifo_rr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_L,
  input  logic i_init,
  input  logic i_enable,
  input  logic i_empty_d0,
  input  logic i_empty_d1,
  input  logic i_popped_d0,
  input  logic i_popped_d1,
  output logic o_grant_valid,
  output logic o_grant_src
);

  logic w_elig_d0;
  logic w_elig_d1;
  logic r_pref;

  assign w_elig_d0 = ~i_empty_d0 & ~i_popped_d0;
  assign w_elig_d1 = ~i_empty_d1 & ~i_popped_d1;

  // Pick a source: preferred one on contention, otherwise whichever is eligible
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_src   = c_SRC_D0;
    if (i_enable) begin
      if (w_elig_d0 && w_elig_d1) begin
        o_grant_valid = 1'b1;
        o_grant_src   = r_pref;
      end else if (w_elig_d0) begin
        o_grant_valid = 1'b1;
        o_grant_src   = c_SRC_D0;
      end else if (w_elig_d1) begin
        o_grant_valid = 1'b1;
        o_grant_src   = c_SRC_D1;
      end
    end
  end

  // Preference flips to the other source after every grant
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_pref <= c_SRC_D0;
    end else if (!i_init) begin
      r_pref <= c_SRC_D0;
    end else if (o_grant_valid) begin
      r_pref <= ~o_grant_src;
    end
  end

endmodule : fifo_rr_arbiter_rr_grant
`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_arbiter
// Brief    : Pops words from lane FIFOs D0/D1 under round-robin arbitration
//            and pushes them into the downstream FIFO. Pop-to-push latency is
//            two cycles; almost-full stops new pops while in-flight words
//            still land. Counts forwarded words per source and flags pushes
//            into a full downstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  init,
  input  logic                  empty_D0,
  input  logic                  empty_D1,
  input  logic [DATA_WIDTH-1:0] data_in_D0,
  input  logic [DATA_WIDTH-1:0] data_in_D1,
  input  logic                  almost_full_down,
  input  logic                  full_down,
  output logic                  pop_D0,
  output logic                  pop_D1,
  output logic                  push_down,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  cnt_D0,
  output logic [CNT_WIDTH-1:0]  cnt_D1,
  output logic                  idle,
  output logic                  error
);

  arb_state_t              r_state;
  logic                    r_pop_d0;
  logic                    r_pop_d1;
  logic                    r_s1_valid;   // FIFO is presenting the popped word
  logic                    r_s1_src;
  logic                    r_push;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0]    r_cnt_d0;
  logic [CNT_WIDTH-1:0]    r_cnt_d1;
  logic                    r_error;

  logic                    w_issue_en;
  logic                    w_grant_valid;
  logic                    w_grant_src;
  logic                    w_any_ready;
  logic                    w_pop_pending;

  assign w_any_ready   = ~empty_D0 | ~empty_D1;
  assign w_pop_pending = r_pop_d0 | r_pop_d1;
  // Never pop while almost-full so at most two words land after the flag rises
  assign w_issue_en    = (r_state == ACTIVE) && !almost_full_down;

  fifo_rr_arbiter_rr_grant u_rr_grant (
    .clk           (clk),
    .reset_L       (reset_L),
    .i_init        (init),
    .i_enable      (w_issue_en),
    .i_empty_d0    (empty_D0),
    .i_empty_d1    (empty_D1),
    .i_popped_d0   (r_pop_d0),
    .i_popped_d1   (r_pop_d1),
    .o_grant_valid (w_grant_valid),
    .o_grant_src   (w_grant_src)
  );

  // FSM and registered pop strobes
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_pop_d0 <= 1'b0;
      r_pop_d1 <= 1'b0;
    end else if (!init) begin
      r_state  <= IDLE;
      r_pop_d0 <= 1'b0;
      r_pop_d1 <= 1'b0;
    end else begin
      r_pop_d0 <= w_grant_valid && (w_grant_src == c_SRC_D0);
      r_pop_d1 <= w_grant_valid && (w_grant_src == c_SRC_D1);
      case (r_state)
        IDLE: begin
          if (w_any_ready && !almost_full_down) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (almost_full_down)
            r_state <= HOLD;
          else if (!w_any_ready && !w_pop_pending)
            r_state <= IDLE;
        end
        HOLD: begin
          if (!almost_full_down) r_state <= w_any_ready ? ACTIVE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Data pipeline: track the pop for one cycle, then capture and push
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_s1_valid <= 1'b0;
      r_s1_src   <= c_SRC_D0;
      r_push     <= 1'b0;
      r_data     <= '0;
      r_cnt_d0   <= '0;
      r_cnt_d1   <= '0;
    end else if (!init) begin
      r_s1_valid <= 1'b0;
      r_s1_src   <= c_SRC_D0;
      r_push     <= 1'b0;
      r_data     <= '0;
      r_cnt_d0   <= '0;
      r_cnt_d1   <= '0;
    end else begin
      r_s1_valid <= r_pop_d0 | r_pop_d1;
      r_s1_src   <= r_pop_d1 ? c_SRC_D1 : c_SRC_D0;
      r_push     <= r_s1_valid;
      if (r_s1_valid) begin
        if (r_s1_src == c_SRC_D1) begin
          r_data   <= data_in_D1;
          r_cnt_d1 <= r_cnt_d1 + CNT_WIDTH'(1);
        end else begin
          r_data   <= data_in_D0;
          r_cnt_d0 <= r_cnt_d0 + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Sticky overflow flag: a push was presented to a full downstream FIFO
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_error <= 1'b0;
    end else if (!init) begin
      r_error <= 1'b0;
    end else if (r_push && full_down) begin
      r_error <= 1'b1;
    end
  end

  assign pop_D0    = r_pop_d0;
  assign pop_D1    = r_pop_d1;
  assign push_down = r_push;
  assign data_out  = r_data;
  assign cnt_D0    = r_cnt_d0;
  assign cnt_D1    = r_cnt_d1;
  assign error     = r_error;
  assign idle      = (r_state == IDLE) && !r_pop_d0 && !r_pop_d1 && !r_s1_valid;

endmodule : fifo_rr_arbiter
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_arbiter
// Brief    : Directed self-checking bench for fifo_rr_arbiter with simple
//            behavioural lane FIFOs and a push/pop logger.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_L = 1'b0;
  logic          init = 1'b0;
  logic          empty_D0;
  logic          empty_D1;
  logic [DW-1:0] data_in_D0;
  logic [DW-1:0] data_in_D1;
  logic          almost_full_down = 1'b0;
  logic          full_down = 1'b0;
  logic          pop_D0;
  logic          pop_D1;
  logic          push_down;
  logic [DW-1:0] data_out;
  logic [CW-1:0] cnt_D0;
  logic [CW-1:0] cnt_D1;
  logic          idle;
  logic          error;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .init             (init),
    .empty_D0         (empty_D0),
    .empty_D1         (empty_D1),
    .data_in_D0       (data_in_D0),
    .data_in_D1       (data_in_D1),
    .almost_full_down (almost_full_down),
    .full_down        (full_down),
    .pop_D0           (pop_D0),
    .pop_D1           (pop_D1),
    .push_down        (push_down),
    .data_out         (data_out),
    .cnt_D0           (cnt_D0),
    .cnt_D1           (cnt_D1),
    .idle             (idle),
    .error            (error)
  );

  // Lane FIFO models: data_out updates the edge after rd_enable, empty follows
  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  logic [9:0]    wr0 = '0;
  logic [9:0]    wr1 = '0;
  logic [9:0]    rd0;
  logic [9:0]    rd1;

  assign empty_D0 = (wr0 == rd0);
  assign empty_D1 = (wr1 == rd1);

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L || !init) begin
      rd0 <= wr0;
      rd1 <= wr1;
      data_in_D0 <= '0;
      data_in_D1 <= '0;
    end else begin
      if (pop_D0 && !empty_D0) begin
        data_in_D0 <= mem0[rd0];
        rd0 <= rd0 + 10'd1;
      end
      if (pop_D1 && !empty_D1) begin
        data_in_D1 <= mem1[rd1];
        rd1 <= rd1 + 10'd1;
      end
    end
  end

  // Logger of pops and pushes seen at each rising edge
  int            cyc  = 0;
  int            npop = 0;
  int            npush = 0;
  logic          pop_src_log [0:1023];
  int            pop_cyc_log [0:1023];
  logic [DW-1:0] push_dat_log [0:1023];
  int            push_cyc_log [0:1023];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((pop_D0 || pop_D1) && npop < 1024) begin
      pop_src_log[npop] <= pop_D1;
      pop_cyc_log[npop] <= cyc;
      npop <= npop + 1;
    end
    if (push_down && npush < 1024) begin
      push_dat_log[npush] <= data_out;
      push_cyc_log[npush] <= cyc;
      npush <= npush + 1;
    end
  end

  task automatic load_d0(input logic [DW-1:0] v);
    mem0[wr0] = v;
    wr0 = wr0 + 10'd1;
  endtask

  task automatic load_d1(input logic [DW-1:0] v);
    mem1[wr1] = v;
    wr1 = wr1 + 10'd1;
  endtask

  task automatic do_init;
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    init = 1'b1;
  endtask

  task automatic test_reset;
    logic [26:0] obs;
    int i;
    reset_L = 1'b0; init = 1'b0; almost_full_down = 1'b0; full_down = 1'b0;
    repeat (3) @(negedge clk);
    obs = {pop_D0, pop_D1, push_down, data_out, cnt_D0, cnt_D1, error, idle};
    n_cmp++;
    if (obs !== {26'd0, 1'b1}) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, {26'd0, 1'b1}); end
    reset_L = 1'b1;
    repeat (2) @(negedge clk);
    obs = {pop_D0, pop_D1, push_down, data_out, cnt_D0, cnt_D1, error, idle};
    n_cmp++;
    if (obs !== {26'd0, 1'b1}) begin n_fail++; $display("FAIL init_hold: got %h expected %h", obs, {26'd0, 1'b1}); end
    init = 1'b1;
    load_d0(6'h11); load_d0(6'h12); load_d0(6'h13);
    for (i = 0; i < 10 && !pop_D0; i++) @(negedge clk);
    n_cmp++;
    if (pop_D0 !== 1'b1) begin n_fail++; $display("FAIL reset_wait_pop: got %b expected 1 (timeout)", pop_D0); end
    #1 reset_L = 1'b0;
    #1 obs = {pop_D0, pop_D1, push_down, data_out, cnt_D0, cnt_D1, error, idle};
    n_cmp++;
    if (obs !== {26'd0, 1'b1}) begin n_fail++; $display("FAIL reset_async: got %h expected %h", obs, {26'd0, 1'b1}); end
    @(negedge clk);
    init = 1'b0;
    reset_L = 1'b1;
    repeat (3) @(negedge clk);
    obs = {pop_D0, pop_D1, push_down, data_out, cnt_D0, cnt_D1, error, idle};
    n_cmp++;
    if (obs !== {26'd0, 1'b1}) begin n_fail++; $display("FAIL reset_release_init_low: got %h expected %h", obs, {26'd0, 1'b1}); end
    init = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    int p0, q0, bad;
    logic [DW-1:0] exp_d [0:2];
    exp_d[0] = 6'h05; exp_d[1] = 6'h0A; exp_d[2] = 6'h3F;
    do_init;
    p0 = npop; q0 = npush;
    load_d0(6'h05); load_d0(6'h0A); load_d0(6'h3F);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (npop - p0 != 3) begin n_fail++; $display("FAIL single_pop_count: got %0d expected 3", npop - p0); end
    bad = 0;
    for (int i = 0; i < 3; i++) if (pop_src_log[p0+i] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL single_pop_src: got %0d D1 pops expected 0", bad); end
    bad = 0;
    for (int i = 1; i < 3; i++) if (pop_cyc_log[p0+i] - pop_cyc_log[p0+i-1] != 2) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL single_pop_spacing: got %0d gaps not 2 expected 0", bad); end
    n_cmp++;
    if (npush - q0 != 3) begin n_fail++; $display("FAIL single_push_count: got %0d expected 3", npush - q0); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (push_dat_log[q0+i] !== exp_d[i]) begin
        n_fail++; $display("FAIL single_push_data[%0d]: got %h expected %h", i, push_dat_log[q0+i], exp_d[i]);
      end
    end
    bad = 0;
    for (int i = 0; i < 3; i++) if (push_cyc_log[q0+i] - pop_cyc_log[p0+i] != 2) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL single_latency: got %0d words not at 2 cycles expected 0", bad); end
    n_cmp++;
    if ({cnt_D0, cnt_D1, idle} !== {8'd3, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL single_end: got cnt_D0=%0d cnt_D1=%0d idle=%b expected 3 0 1", cnt_D0, cnt_D1, idle);
    end
  endtask

  task automatic test_rr;
    int p0, q0, bad;
    logic [DW-1:0] exp_d [0:7];
    exp_d[0] = 6'h10; exp_d[1] = 6'h20; exp_d[2] = 6'h11; exp_d[3] = 6'h21;
    exp_d[4] = 6'h12; exp_d[5] = 6'h22; exp_d[6] = 6'h13; exp_d[7] = 6'h23;
    do_init;
    p0 = npop; q0 = npush;
    for (int i = 0; i < 4; i++) begin
      load_d0(6'h10 + 6'(i));
      load_d1(6'h20 + 6'(i));
    end
    repeat (30) @(negedge clk);
    n_cmp++;
    if (npop - p0 != 8) begin n_fail++; $display("FAIL rr_pop_count: got %0d expected 8", npop - p0); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (pop_src_log[p0+i] !== i[0]) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL rr_alternation: got %0d out-of-order pops expected 0", bad); end
    bad = 0;
    for (int i = 1; i < 8; i++) if (pop_cyc_log[p0+i] - pop_cyc_log[p0+i-1] != 1) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL rr_back_to_back: got %0d idle gaps expected 0", bad); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (push_dat_log[q0+i] !== exp_d[i]) bad++;
    n_cmp++;
    if (bad != 0 || npush - q0 != 8) begin
      n_fail++; $display("FAIL rr_push_order: got %0d wrong words of %0d pushes expected 0 of 8", bad, npush - q0);
    end
    n_cmp++;
    if ({cnt_D0, cnt_D1} !== {8'd4, 8'd4}) begin
      n_fail++; $display("FAIL rr_counts: got %0d/%0d expected 4/4", cnt_D0, cnt_D1);
    end
  endtask

  task automatic test_backpressure;
    int p0, q0, bad, i;
    logic [DW-1:0] exp_d [0:7];
    exp_d[0] = 6'h30; exp_d[1] = 6'h38; exp_d[2] = 6'h31; exp_d[3] = 6'h39;
    exp_d[4] = 6'h32; exp_d[5] = 6'h3A; exp_d[6] = 6'h33; exp_d[7] = 6'h3B;
    do_init;
    p0 = npop; q0 = npush;
    for (int k = 0; k < 4; k++) begin
      load_d0(6'h30 + 6'(k));
      load_d1(6'h38 + 6'(k));
    end
    for (i = 0; i < 10 && !pop_D1; i++) @(negedge clk);
    n_cmp++;
    if (pop_D1 !== 1'b1) begin n_fail++; $display("FAIL bp_wait_pop: got %b expected 1 (timeout)", pop_D1); end
    almost_full_down = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (npop - p0 != 2) begin n_fail++; $display("FAIL bp_hold_pops: got %0d expected 2", npop - p0); end
    n_cmp++;
    if (npush - q0 != 2) begin n_fail++; $display("FAIL bp_inflight_pushes: got %0d expected 2", npush - q0); end
    n_cmp++;
    if ({idle, pop_D0, pop_D1} !== 3'b000) begin
      n_fail++; $display("FAIL bp_hold_state: got idle/pop0/pop1=%b expected 000", {idle, pop_D0, pop_D1});
    end
    almost_full_down = 1'b0;
    repeat (25) @(negedge clk);
    bad = 0;
    for (int k = 0; k < 8; k++) if (pop_src_log[p0+k] !== k[0]) bad++;
    n_cmp++;
    if (bad != 0 || npop - p0 != 8) begin
      n_fail++; $display("FAIL bp_resume_order: got %0d wrong of %0d pops expected 0 of 8", bad, npop - p0);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) if (push_dat_log[q0+k] !== exp_d[k]) bad++;
    n_cmp++;
    if (bad != 0 || npush - q0 != 8) begin
      n_fail++; $display("FAIL bp_push_order: got %0d wrong of %0d pushes expected 0 of 8", bad, npush - q0);
    end
    n_cmp++;
    if ({cnt_D0, cnt_D1, error} !== {8'd4, 8'd4, 1'b0}) begin
      n_fail++; $display("FAIL bp_counts: got %0d/%0d err=%b expected 4/4 err=0", cnt_D0, cnt_D1, error);
    end
  endtask

  task automatic test_overflow;
    int q0, i;
    do_init;
    q0 = npush;
    load_d0(6'h01); load_d0(6'h02);
    for (i = 0; i < 10 && !pop_D0; i++) @(negedge clk);
    n_cmp++;
    if (pop_D0 !== 1'b1) begin n_fail++; $display("FAIL ovf_wait_pop: got %b expected 1 (timeout)", pop_D0); end
    full_down = 1'b1;
    n_cmp++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", error); end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", error); end
    full_down = 1'b0;
    load_d1(6'h07); load_d1(6'h08); load_d1(6'h09);
    repeat (15) @(negedge clk);
    n_cmp++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", error); end
    n_cmp++;
    if ({cnt_D0, cnt_D1} !== {8'd2, 8'd3} || npush - q0 != 5) begin
      n_fail++; $display("FAIL ovf_traffic: got %0d/%0d pushes=%0d expected 2/3 pushes=5", cnt_D0, cnt_D1, npush - q0);
    end
    do_init;
    n_cmp++;
    if ({error, cnt_D0, cnt_D1} !== 17'd0) begin
      n_fail++; $display("FAIL ovf_init_clear: got err=%b cnt=%0d/%0d expected 0 0/0", error, cnt_D0, cnt_D1);
    end
  endtask

  task automatic test_wrap;
    int q0;
    do_init;
    q0 = npush;
    for (int k = 0; k < 256; k++) load_d1(6'(k));
    repeat (600) @(negedge clk);
    n_cmp++;
    if (npush - q0 != 256) begin n_fail++; $display("FAIL wrap_push_count: got %0d expected 256", npush - q0); end
    n_cmp++;
    if ({cnt_D0, cnt_D1} !== 16'd0) begin
      n_fail++; $display("FAIL wrap_counts: got %0d/%0d expected 0/0", cnt_D0, cnt_D1);
    end
    n_cmp++;
    if (push_dat_log[q0+255] !== 6'h3F) begin
      n_fail++; $display("FAIL wrap_last_word: got %h expected 3f", push_dat_log[q0+255]);
    end
    n_cmp++;
    if ({error, idle} !== 2'b01) begin
      n_fail++; $display("FAIL wrap_end_flags: got err/idle=%b expected 01", {error, idle});
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rr;
    test_backpressure;
    test_overflow;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fifo_rr_arbiter
`default_nettype wire
